// File: rtl/adpll_loop_filter.sv
// ADPLL proportional-integral loop filter with gear-shift lock detection.
// Turns signed phase-error samples into a 13-bit DCO control code.
module adpll_loop_filter #(
  parameter int KP_SHIFT_ACQ = 2,
  parameter int KI_SHIFT_ACQ = 4,
  parameter int KP_SHIFT_TRK = 4,
  parameter int KI_SHIFT_TRK = 7,
  parameter int LOCK_THRESH  = 4,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int INIT_CODE    = 4096
) (
  input  logic        ref_clk,
  input  logic        reset,
  input  logic [7:0]  phase_error,
  input  logic        error_valid,
  input  logic        hold,
  output logic [12:0] filter_output,
  output logic        filter_update,
  output logic        locked,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACQUIRE = 2'b01,
    TRACK   = 2'b10
  } state_t;

  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [LW-1:0] LMAX = LW'(LOCK_COUNT);
  localparam logic [UW-1:0] UMAX = UW'(UNLOCK_COUNT);
  localparam logic [12:0] INIT = 13'(INIT_CODE);
  localparam logic [8:0] THRESH = 9'(LOCK_THRESH);

  state_t st, st_nx;
  logic [LW-1:0] lock_cnt, lock_nx;
  logic [UW-1:0] unlock_cnt, unlock_nx;

  logic              smp_vld;
  logic [7:0]        smp_err;
  logic [20:0]       integ, integ_clamp;
  logic [12:0]       out_clamp;
  logic signed [20:0] e, ki, kp;
  logic signed [22:0] isum, osum, ocode;
  logic [8:0]        mag;
  logic              good, trk;

  assign trk = (st == TRACK);

  // Gains follow the state current when the sample is processed.
  always_comb begin
    e = {{5{smp_err[7]}}, smp_err, 8'd0};
    ki = trk ? (e >>> KI_SHIFT_TRK) : (e >>> KI_SHIFT_ACQ);
    kp = trk ? (e >>> KP_SHIFT_TRK) : (e >>> KP_SHIFT_ACQ);
    isum = $signed({2'b00, integ}) + $signed({{2{ki[20]}}, ki});
    if (isum < 0)
      integ_clamp = '0;
    else if (isum > 23'sd2097151)
      integ_clamp = '1;
    else
      integ_clamp = isum[20:0];
    osum = $signed({2'b00, integ_clamp}) + $signed({{2{kp[20]}}, kp});
    ocode = osum >>> 8;
    if (ocode < 0)
      out_clamp = '0;
    else if (ocode > 23'sd8191)
      out_clamp = '1;
    else
      out_clamp = ocode[12:0];
    mag = smp_err[7] ? (9'd0 - {1'b1, smp_err}) : {1'b0, smp_err};
    good = (mag <= THRESH);
  end

  always_comb begin
    st_nx = st;
    lock_nx = lock_cnt;
    unlock_nx = unlock_cnt;
    if (smp_vld) begin
      unique case (1'b1)
        (st != TRACK): begin
          st_nx = ACQUIRE;
          if (!good) begin
            lock_nx = '0;
          end else if (lock_cnt >= LMAX - LW'(1)) begin
            st_nx = TRACK;
            lock_nx = '0;
            unlock_nx = '0;
          end else begin
            lock_nx = lock_cnt + LW'(1);
          end
        end
        (st == TRACK): begin
          if (good) begin
            unlock_nx = '0;
          end else if (unlock_cnt >= UMAX - UW'(1)) begin
            st_nx = ACQUIRE;
            lock_nx = '0;
            unlock_nx = '0;
          end else begin
            unlock_nx = unlock_cnt + UW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      smp_vld       <= 1'b0;
      smp_err       <= '0;
      integ         <= {INIT, 8'd0};
      filter_output <= INIT;
      filter_update <= 1'b0;
      locked        <= 1'b0;
      st            <= IDLE;
      lock_cnt      <= '0;
      unlock_cnt    <= '0;
    end else begin
      smp_vld <= error_valid & ~hold;
      if (error_valid & ~hold)
        smp_err <= phase_error;
      filter_update <= smp_vld;
      if (smp_vld) begin
        integ         <= integ_clamp;
        filter_output <= out_clamp;
      end
      st         <= st_nx;
      lock_cnt   <= lock_nx;
      unlock_cnt <= unlock_nx;
      locked     <= (st_nx == TRACK);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_adpll_loop_filter.sv
// Bench for adpll_loop_filter: three instances with different start codes
// checked every cycle against an integer-arithmetic model plus literals.
module tb_adpll_loop_filter;

  logic        ref_clk = 1'b0;
  logic        reset = 1'b1;
  logic        error_valid = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  phase_error = '0;

  logic [12:0] fo [3];
  logic        fu [3];
  logic        lk [3];
  logic [1:0]  st [3];

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  int init_code [3] = '{4096, 8190, 1};

  always #5 ref_clk = ~ref_clk;

  adpll_loop_filter u0 (
    .ref_clk(ref_clk), .reset(reset), .phase_error(phase_error),
    .error_valid(error_valid), .hold(hold), .filter_output(fo[0]),
    .filter_update(fu[0]), .locked(lk[0]), .state(st[0]));

  adpll_loop_filter #(.INIT_CODE(8190)) u1 (
    .ref_clk(ref_clk), .reset(reset), .phase_error(phase_error),
    .error_valid(error_valid), .hold(hold), .filter_output(fo[1]),
    .filter_update(fu[1]), .locked(lk[1]), .state(st[1]));

  adpll_loop_filter #(.INIT_CODE(1)) u2 (
    .ref_clk(ref_clk), .reset(reset), .phase_error(phase_error),
    .error_valid(error_valid), .hold(hold), .filter_output(fo[2]),
    .filter_update(fu[2]), .locked(lk[2]), .state(st[2]));

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Model state: integrator in 1/256 units, code, strobe, mode 0/1/2.
  int m_integ [3];
  int m_out [3];
  int m_upd [3];
  int m_st [3];
  int m_lc [3];
  int m_uc [3];
  int p_v;
  int p_e;

  always @(posedge ref_clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        m_integ[i] <= init_code[i] * 256;
        m_out[i]   <= init_code[i];
        m_upd[i]   <= 0;
        m_st[i]    <= 0;
        m_lc[i]    <= 0;
        m_uc[i]    <= 0;
      end
      p_v <= 0;
      p_e <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        int ki, kp, ig, mag;
        bit trk, good;
        m_upd[i] <= p_v;
        if (p_v != 0) begin
          trk = (m_st[i] == 2);
          ki = (p_e * 256) >>> (trk ? 7 : 4);
          kp = (p_e * 256) >>> (trk ? 4 : 2);
          ig = clamp(m_integ[i] + ki, 0, 2097151);
          m_integ[i] <= ig;
          m_out[i] <= clamp((ig + kp) >>> 8, 0, 8191);
          mag = (p_e < 0) ? -p_e : p_e;
          good = (mag <= 4);
          if (!trk) begin
            if (!good) begin
              m_st[i] <= 1;
              m_lc[i] <= 0;
            end else if (m_lc[i] + 1 == 16) begin
              m_st[i] <= 2;
              m_lc[i] <= 0;
              m_uc[i] <= 0;
            end else begin
              m_st[i] <= 1;
              m_lc[i] <= m_lc[i] + 1;
            end
          end else begin
            if (good) begin
              m_uc[i] <= 0;
            end else if (m_uc[i] + 1 == 4) begin
              m_st[i] <= 1;
              m_lc[i] <= 0;
              m_uc[i] <= 0;
            end else begin
              m_uc[i] <= m_uc[i] + 1;
            end
          end
        end
      end
      p_v <= (error_valid && !hold) ? 1 : 0;
      p_e <= int'($signed(phase_error));
    end
  end

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  always @(negedge ref_clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.filter_output", i), int'(fo[i]), m_out[i]);
        chk($sformatf("u%0d.filter_update", i), int'(fu[i]), m_upd[i]);
        chk($sformatf("u%0d.locked", i), int'(lk[i]), (m_st[i] == 2) ? 1 : 0);
        chk($sformatf("u%0d.state", i), int'(st[i]), m_st[i]);
      end
    end
  end

  task automatic put(input int v, input bit h = 1'b0);
    phase_error = 8'(v);
    error_valid = 1'b1;
    hold = h;
    @(negedge ref_clk);
    error_valid = 1'b0;
    hold = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ref_clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    @(negedge ref_clk);
    @(negedge ref_clk);
    chk_en = 1;
    chk("reset_code", int'(fo[0]), 4096);
    chk("reset_state", int'(st[0]), 0);
    reset = 1'b0;

    // First sample and proportional return
    put(16);
    idle(1);
    chk("first_code", int'(fo[0]), 4101);
    chk("first_update", int'(fu[0]), 1);
    chk("first_state", int'(st[0]), 1);
    put(0);
    idle(1);
    chk("prop_return", int'(fo[0]), 4097);
    idle(1);
    chk("update_drop", int'(fu[0]), 0);

    // Lock entry with a restart at position 10
    do_reset();
    repeat (9) put(2);
    put(5);
    repeat (15) put(2);
    idle(1);
    chk("not_locked_15", int'(lk[0]), 0);
    put(2);
    idle(1);
    chk("locked_16", int'(lk[0]), 1);
    chk("track_state", int'(st[0]), 2);

    // Unlock run in TRACK gains
    repeat (3) put(100);
    put(3);
    repeat (3) put(-50);
    idle(1);
    chk("still_track", int'(st[0]), 2);
    put(-50);
    idle(1);
    chk("unlock_state", int'(st[0]), 1);
    chk("unlock_locked", int'(lk[0]), 0);

    // Hold collision
    put(64, 1'b1);
    idle(1);
    chk("hold_no_update", int'(fu[0]), 0);

    // Reset collision while in TRACK
    repeat (16) put(2);
    idle(1);
    chk("relock", int'(lk[0]), 1);
    put(2);
    phase_error = 8'd2;
    error_valid = 1'b1;
    reset = 1'b1;
    @(negedge ref_clk);
    reset = 1'b0;
    error_valid = 1'b0;
    chk("rst_state", int'(st[0]), 0);
    chk("rst_locked", int'(lk[0]), 0);
    chk("rst_code", int'(fo[0]), 4096);
    idle(1);
    chk("rst_no_update", int'(fu[0]), 0);

    // Saturation high and low
    do_reset();
    put(127);
    idle(1);
    chk("sat_hi_first", int'(fo[1]), 8191);
    repeat (50) put(127);
    idle(1);
    chk("sat_hi", int'(fo[1]), 8191);
    do_reset();
    repeat (10) put(-128);
    idle(1);
    chk("sat_lo", int'(fo[2]), 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/adpll_loop_filter.md
# adpll_loop_filter

Digital proportional-integral loop filter for the ADPLL, running on the reference clock between the phase detector and the DCO decoder. Each valid signed phase-error sample updates a saturating integrator and produces the 13-bit unsigned `filter_output` code consumed by the DCO decoder. The filter also runs a gear-shift lock FSM that switches from wide acquisition gains to narrow tracking gains. A one-cycle `filter_update` strobe marks every cycle in which a new code becomes visible.

## Interface
- `KP_SHIFT_ACQ`, default 2: proportional right-shift in ACQUIRE.
- `KI_SHIFT_ACQ`, default 4: integral right-shift in ACQUIRE.
- `KP_SHIFT_TRK`, default 4: proportional right-shift in TRACK.
- `KI_SHIFT_TRK`, default 7: integral right-shift in TRACK.
- `LOCK_THRESH`, default 4: largest |error| that counts as a good sample.
- `LOCK_COUNT`, default 16: number of consecutive good samples needed to enter TRACK.
- `UNLOCK_COUNT`, default 4: number of consecutive bad samples needed to fall back to ACQUIRE.
- `INIT_CODE`, default 4096: reset and restart value of the output code, range 0..8191.
- `ref_clk`, in, 1: reference clock. All state changes on its rising edge.
- `reset`, in, 1: reset. Synchronous, active-high.
- `phase_error`, in, 8: signed two's-complement phase error.
- `error_valid`, in, 1: qualifies `phase_error` for one cycle.
- `hold`, in, 1: freeze. While high, valid samples are ignored.
- `filter_output`, out, 13: unsigned DCO control code.
- `filter_update`, out, 1: one-cycle pulse when `filter_output` is rewritten.
- `locked`, out, 1: high while the FSM is in TRACK.
- `state`, out, 2: 00 IDLE, 01 ACQUIRE, 10 TRACK.

## Operation
- **Accepted sample:** `error_valid & ~hold & ~reset`. Nothing else changes any register except reset.
- **Integrator (`integ`):** 21-bit unsigned, Q13.8 (8 fractional bits).
  - Reset value is `INIT_CODE<<8`.
- **Error scaling:** `e = phase_error` sign-extended to 21 bits, then `<<<8`.
  - `ki = e >>> KI_SHIFT`.
  - `kp = e >>> KP_SHIFT`.
  - Both shifts are arithmetic and truncate toward −∞.
  - The shift values are the gains of the state the FSM is in when the sample arrives.
- **Integrator update:** `integ_next = clamp(integ + ki, 0, 2^21−1)`.
  - The sum is computed at 22 bits signed before clamping.
- **Output:** `filter_output = clamp((integ_next + kp) >>> 8, 0, 8191)`.
  - The sum is computed at 23 bits signed.
  - The proportional term is not stored. The code returns toward the integrator value on the next sample.
- **Error magnitude:** `|phase_error|` is computed at 9 bits, so −128 gives 128.
  - A sample is good when the magnitude is ≤ `LOCK_THRESH` and bad otherwise.
- **FSM:**
  - IDLE → ACQUIRE on the first accepted sample. That sample is processed with ACQUIRE gains.
  - In ACQUIRE:
    - A good sample increments `lock_cnt`; a bad sample clears it.
    - When the good sample brings `lock_cnt` to `LOCK_COUNT`, the FSM goes to TRACK and clears the counter.
  - In TRACK:
    - A bad sample increments `unlock_cnt`; a good sample clears it.
    - When `unlock_cnt` reaches `UNLOCK_COUNT`, the FSM goes to ACQUIRE and clears both counters.
  - The integrator is never cleared on a gear shift.
- **Counters:** sized to hold `LOCK_COUNT` and `UNLOCK_COUNT`. They saturate and never wrap.
- **Reset (including mid-operation):**
  - `integ = INIT_CODE<<8`, `filter_output = INIT_CODE`.
  - `filter_update = 0`, `locked = 0`, `state = IDLE`, both counters 0.
  - Reset wins over a simultaneous `error_valid`.

## Timing
- Latency is one cycle. A sample accepted at edge n produces `filter_output`, `filter_update = 1`, and any new `state`/`locked` value after edge n+1, all in the same cycle.
- `filter_update` is high for exactly one cycle per accepted sample. This holds even when the code value does not change.
- Back-to-back valid samples on every cycle are supported at full rate: one output per cycle with no bubbles.
- `hold` takes effect in the same cycle it is asserted. A sample that coincides with `hold` is dropped, `filter_update` stays low, and the counters are unchanged.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan
- **Reset then first sample** (defaults): assert reset and release it, then one sample with `phase_error=+16` → `filter_output` 4096 during reset. One cycle after the sample: `filter_output=4101` (integ = 4097.0, kp = 4.0), `filter_update` pulses once, and `state=01`.
- **Proportional return:** following the first scenario, send `phase_error=0` → `filter_output=4097`.
- **Lock entry:** 16 consecutive samples of +2 → `locked` rises in the cycle after the 16th sample. A bad sample (+5) at position 10 restarts the count, and `locked` then rises only after 16 more good samples.
- **Unlock:** while in TRACK, send +100, +100, +100, +3, then 4×(−50) → `state` stays TRACK through the first run. It returns to 01 after the 4th −50. The −50 samples use TRACK gains: kp = −3.125 and ki step = −0.390625 before truncation.
- **Saturation:** with `INIT_CODE=8190`, send 50 samples of +127 → `filter_output` pins at 8191 and never wraps. With `INIT_CODE=1`, send −128 samples → `filter_output` pins at 0.
- **Hold and reset collisions:** `hold=1` together with valid +64 → no `filter_update` and no change. Reset asserted in the same cycle as a valid sample while in TRACK → next cycle shows `state=00`, `locked=0`, `filter_output=INIT_CODE`.
